// File: rtl/alu_pkg.sv
// Shared definitions for the execute unit: alucontrol codes and FSM states.
// The ALU decoder takes its code constants from here as well.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_AUIPC = 4'b0100;
   localparam logic [3:0] ALU_BSUB  = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU operations and legal-code detection (purely combinational).
// SLL passes operand A through: that is the shamt-0 result; longer shifts iterate in alu_exec.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       i_alucontrol,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_illegal
);

   always_comb begin
      o_result  = '0;
      o_illegal = 1'b0;
      case (i_alucontrol)
         ALU_AND:             o_result = i_a & i_b;
         ALU_ADD, ALU_AUIPC:  o_result = i_a + i_b;
         ALU_BSUB, ALU_SUB:   o_result = i_a - i_b;
         ALU_SLL:             o_result = i_a;
         ALU_SLT:             o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default:             o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute unit: valid/ready on both sides, iterative SLL, registered result and flags.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_SHIFT | SLL in progress, one bit per cycle
// S_DONE  | result held until the consumer takes it
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [3:0]       i_alucontrol,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_illegal
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic [WIDTH-1:0] w_core_result;
   logic             w_core_illegal;
   logic [SHW-1:0]   w_shamt;
   logic             w_accept;
   logic             w_iter_shift;
   logic             w_last_shift;
   logic [WIDTH-1:0] w_acc_sh;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .i_alucontrol (i_alucontrol),
      .i_a          (i_a),
      .i_b          (i_b),
      .o_result     (w_core_result),
      .o_illegal    (w_core_illegal)
   );

   assign w_shamt      = i_b[SHW-1:0];
   assign w_accept     = i_in_valid && (r_state == S_IDLE);
   assign w_iter_shift = (i_alucontrol == ALU_SLL) && (w_shamt != '0);
   assign w_last_shift = (r_cnt == SHW'(1));
   assign w_acc_sh     = {r_acc[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_iter_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (w_last_shift) w_state_nxt = S_DONE;
         S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_iter_shift) begin
                     r_acc <= i_a;
                     r_cnt <= w_shamt;
                  end else begin
                     r_result  <= w_core_result;
                     r_zero    <= (w_core_result == '0);
                     r_illegal <= w_core_illegal;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= w_acc_sh;
               r_cnt <= r_cnt - SHW'(1);
               if (w_last_shift) begin
                  r_result  <= w_acc_sh;
                  r_zero    <= (w_acc_sh == '0);
                  r_illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = (r_state == S_DONE);
   assign o_result    = r_result;
   assign o_zero      = r_zero;
   assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors, latency, backpressure and mid-op reset.
module tb_alu_exec;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [3:0]  i_alucontrol;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_result;
   logic        o_zero;
   logic        o_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_exec #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_alucontrol (i_alucontrol),
      .i_a          (i_a),
      .i_b          (i_b),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_result     (o_result),
      .o_zero       (o_zero),
      .o_illegal    (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge, wait (bounded) for acceptance, then scramble inputs.
   task automatic accept(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      i_alucontrol = code;
      i_a          = a;
      i_b          = b;
      i_in_valid   = 1'b1;
      n = 0;
      while (!o_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", {31'd0, o_in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      i_in_valid   = 1'b0;
      i_alucontrol = 4'hF;
      i_a          = ~a;
      i_b          = ~b;
   endtask

   // Already one negedge past the accept edge on entry.
   task automatic wait_valid(input string tag, input int exp_lat);
      int n;
      n = 1;
      while (!o_out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, n, exp_lat);
   endtask

   task automatic check_out(input string tag, input logic [31:0] res, input logic z, input logic ill);
      check({tag, "_result"}, o_result, res);
      check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, z});
      check({tag, "_illegal"}, {31'd0, o_illegal}, {31'd0, ill});
   endtask

   task automatic consume(input string tag);
      i_out_ready = 1'b1;
      @(negedge clk);
      i_out_ready = 1'b0;
      check({tag, "_in_ready_after"}, {31'd0, o_in_ready}, 32'd1);
      check({tag, "_out_valid_after"}, {31'd0, o_out_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [3:0] code, input logic [31:0] a,
                      input logic [31:0] b, input int lat, input logic [31:0] res,
                      input logic z, input logic ill);
      accept(code, a, b);
      wait_valid({tag, "_latency"}, lat);
      check_out(tag, res, z, ill);
      consume(tag);
   endtask

   initial begin
      logic [31:0] held_res;
      logic        saw_valid;

      rst_n        = 1'b0;
      i_in_valid   = 1'b0;
      i_out_ready  = 1'b0;
      i_alucontrol = 4'h0;
      i_a          = 32'h0;
      i_b          = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", {31'd0, o_in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
      check_out("reset", 32'h0, 1'b0, 1'b0);

      run("add_ovf",   ALU_ADD,   32'h7FFF_FFFF, 32'h1,         1, 32'h8000_0000, 1'b0, 1'b0);
      run("bsub_eq",   ALU_BSUB,  32'h1234,      32'h1234,      1, 32'h0,         1'b1, 1'b0);
      run("sub_wrap",  ALU_SUB,   32'h0,         32'h1,         1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run("auipc",     ALU_AUIPC, 32'h0000_1000, 32'h0001_2000, 1, 32'h0001_3000, 1'b0, 1'b0);
      run("slt_neg",   ALU_SLT,   32'hFFFF_FFFF, 32'h1,         1, 32'h1,         1'b0, 1'b0);
      run("slt_pos",   ALU_SLT,   32'h1,         32'hFFFF_FFFF, 1, 32'h0,         1'b1, 1'b0);
      run("and",       ALU_AND,   32'hF0F0,      32'h0FF0,      1, 32'h00F0,      1'b0, 1'b0);
      run("sll5",      ALU_SLL,   32'h1,         32'h5,         6, 32'h20,        1'b0, 1'b0);
      run("sll_sh0",   ALU_SLL,   32'h1,         32'h20,        1, 32'h1,         1'b0, 1'b0);
      run("sll31",     ALU_SLL,   32'h1,         32'd31,        32, 32'h8000_0000, 1'b0, 1'b0);
      run("sll_out",   ALU_SLL,   32'hC000_0001, 32'd2,         3, 32'h4,         1'b0, 1'b0);
      run("illegal_f", 4'hF,      32'h1234,      32'h5678,      1, 32'h0,         1'b1, 1'b1);
      run("illegal_3", 4'h3,      32'h1,         32'h1,         1, 32'h0,         1'b1, 1'b1);

      // Backpressure: result held five cycles with a new request pending.
      accept(ALU_ADD, 32'd100, 32'd23);
      wait_valid("bp_latency", 1);
      held_res     = o_result;
      check("bp_result", held_res, 32'd123);
      i_in_valid   = 1'b1;
      i_alucontrol = ALU_SUB;
      i_a          = 32'd5;
      i_b          = 32'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", {31'd0, o_out_valid}, 32'd1);
         check("bp_hold_result", o_result, held_res);
         check("bp_hold_in_ready", {31'd0, o_in_ready}, 32'd0);
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      i_out_ready = 1'b0;
      check("bp_in_ready_after", {31'd0, o_in_ready}, 32'd1);
      // The held SUB request is accepted on the next edge.
      @(negedge clk);
      i_in_valid = 1'b0;
      check("held_req_valid", {31'd0, o_out_valid}, 32'd1);
      check("held_req_result", o_result, 32'd2);
      consume("held_req");

      // Reset during the 10th shift cycle of a 20-bit shift.
      accept(ALU_SLL, 32'h1, 32'd20);
      repeat (9) @(negedge clk);
      check("pre_rst_in_ready", {31'd0, o_in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", {31'd0, o_in_ready}, 32'd1);
      check("rst_mid_out_valid", {31'd0, o_out_valid}, 32'd0);
      check_out("rst_mid", 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (o_out_valid) saw_valid = 1'b1;
      end
      check("rst_no_stale_valid", {31'd0, saw_valid}, 32'd0);
      run("add_after_rst", ALU_ADD, 32'd7, 32'd8, 1, 32'd15, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle RISC-V execute unit: consumes the 4-bit `alucontrol` code from the ALU decoder together with two operands and returns a registered result and flags. It sits in the datapath between decode/operand select and writeback/branch logic. The unit runs a valid/ready handshake on both sides, so the pipeline can stall on the iterative shift.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived).

- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request.
- `alucontrol`  in  4  operation code (see Operation).
- `a`  in  WIDTH  operand A (rs1 or PC).
- `b`  in  WIDTH  operand B (rs2 or immediate; AUIPC immediate already shifted left by 12).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered `result == 0`.
- `illegal`  out  1  registered; the code was not recognised.

## Operation
- Codes:
  - 0000 AND: `a & b`
  - 0010 ADD: `a + b`
  - 0100 AUIPC: `a + b`
  - 0101 BSUB (branch compare): `a - b`
  - 0110 SUB: `a - b`
  - 0111 SLL: `a << b[SHW-1:0]`
  - 1000 SLT: `{0…, $signed(a) < $signed(b)}`
  - any other code: `result = 0`, `illegal = 1`.
- Arithmetic is modulo 2^WIDTH; carry and overflow are discarded.
- `zero` is computed from the final result, including for illegal codes (`result = 0`, so `zero = 1`).
- Operands and code are captured at the accept edge; later input changes have no effect.
- FSM:
  - IDLE: `in_ready = 1`. On accept, a non-SLL op, or SLL with shamt 0, goes to DONE with the result registered. SLL with shamt s > 0 goes to SHIFT with `acc = a`, `cnt = s`.
  - SHIFT: each cycle `acc <= acc << 1`, `cnt <= cnt - 1`. When `cnt == 1`, registers `result = acc << 1` and goes to DONE.
  - DONE: `out_valid = 1`; outputs are held stable. When `out_ready` is high, goes to IDLE.
- `in_ready` is high only in IDLE. Requests never overlap and nothing is queued.
- Reset values: state IDLE, `in_ready` 1 (after reset), `out_valid` 0, `result` 0, `zero` 0, `illegal` 0, `acc`/`cnt` 0.

## Timing
- Accept at cycle N (`in_valid & in_ready` on the edge):
  - non-SLL or shamt 0: `out_valid` is high from cycle N+1.
  - SLL with shamt s: `out_valid` is high from cycle N+1+s. Maximum latency is WIDTH cycles (s = WIDTH-1).
- Result handoff happens on the edge where `out_valid & out_ready`. `in_ready` rises the following cycle, so the minimum period is 2 cycles per op.
- `out_ready` held high beforehand: the result is consumed on its first valid cycle.
- `in_valid` is ignored outside IDLE. A held request is accepted on IDLE re-entry.
- Reset asserted mid-SHIFT or in DONE: immediate return to IDLE with reset values. The pending result is discarded and `out_valid` is never produced for it.
- No combinational path from any input to any output except `in_ready` and `out_valid`, which are decoded from the state register only.

## Structure
- Shared package `alu_pkg`:
  - localparams for all `alucontrol` codes (`ALU_AND`, `ALU_ADD`, `ALU_AUIPC`, `ALU_BSUB`, `ALU_SUB`, `ALU_SLL`, `ALU_SLT`).
  - the FSM state enum (`S_IDLE`, `S_SHIFT`, `S_DONE`).
  - The decoder uses the same code constants.
- Sub-module `alu_core`: purely combinational single-cycle ops (all except the iterative SLL) plus the legal-code check. `alu_exec` holds the FSM, the shift accumulator and the output registers.

## Test plan
- Reset then idle: hold `rst_n` = 0, release → `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 0, `illegal` = 0.
- ADD/SUB/BSUB:
  - ADD a=0x7FFFFFFF, b=1 → after 1 cycle `result` = 0x80000000, `zero` = 0.
  - BSUB a=b=0x1234 → `result` = 0, `zero` = 1.
  - SUB a=0, b=1 → 0xFFFFFFFF.
- SLT signedness: a=0xFFFFFFFF (−1), b=1 → `result` = 1; a=1, b=0xFFFFFFFF → `result` = 0. AND 0xF0F0, 0x0FF0 → 0x00F0.
- SLL latency:
  - a=1, b=5 → `out_valid` exactly 6 cycles after accept, `result` = 0x20.
  - b=0x20 (shamt 0) → 1 cycle, `result` = 1.
  - b=31 → 32 cycles, `result` = 0x80000000.
- Backpressure and illegal code:
  - `out_ready` = 0 for 5 cycles → `result`/`out_valid` stay stable and `in_ready` stays 0.
  - code 0xF → `illegal` = 1, `result` = 0, `zero` = 1.
- Reset mid-operation: SLL shamt 20, assert `rst_n` = 0 at the 10th shift cycle → outputs return to reset values at once. After release, no `out_valid` appears, and a new ADD completes normally.
